// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_DM_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - 8-bit watchdog counter with enable, clear and terminal count
module arb_watchdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [7:0] cnt;

  // Fires in the cycle whose increment would bring the count to LIMIT.
  assign tc = en && (cnt == LIMIT - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and MEM stage accesses onto one variable-latency memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       owner;
  logic [3:0] starve_cnt;
  logic       busy;
  logic       wd_tc;
  logic       dm_wins;

  assign if_stall = if_req && !if_done;
  assign dm_stall = dm_req && !dm_done;
  assign busy     = (state == ST_IF_BUSY) || (state == ST_DM_BUSY);
  assign dm_wins  = dm_req && (!if_req || (starve_cnt < STARVE_LIM));

  arb_watchdog #(
    .LIMIT(8'(TIMEOUT))
  ) u_watchdog (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .clr  (!busy || mem_ready),
    .tc   (wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= PORT_IF;
      starve_cnt  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dm_wins) begin
            state      <= ST_DM_BUSY;
            owner      <= PORT_DM;
            mem_req    <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            starve_cnt <= if_req ? sat_inc4(starve_cnt) : 4'd0;
          end else if (if_req) begin
            state      <= ST_IF_BUSY;
            owner      <= PORT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= 4'd0;
          end
        end
        ST_IF_BUSY, ST_DM_BUSY: begin
          // mem_ready wins over a watchdog expiry landing in the same cycle.
          if (mem_ready || wd_tc) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ready) begin
              err_timeout <= 1'b1;
            end
            if (owner == PORT_IF) begin
              if_rdata <= mem_ready ? mem_rdata : '0;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) begin
                dm_rdata <= mem_ready ? mem_rdata : '0;
              end
              dm_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_stall, if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_stall, dm_done;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err_timeout;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_model [logic [31:0]];
  int          mem_lat = 1;
  bit          mem_dead = 1'b0;
  bit          force_ready = 1'b0;
  int          busy_cnt = 0;
  logic [31:0] exp_dm_rdata = '0;
  logic [31:0] last_if = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: answers in the mem_lat-th busy cycle unless mem_dead.
  always @(negedge clk) begin
    if (mem_req) begin
      busy_cnt = busy_cnt + 1;
      if (!mem_dead && busy_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd_model(mem_addr);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
      end
    end else begin
      busy_cnt  = 0;
      mem_ready = force_ready;
      mem_rdata = force_ready ? 32'h0BAD_F00D : 32'h0;
    end
  end

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_done || dm_done) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_unexpected_done if_done=%0b dm_done=%0b required=none", if_done, dm_done);
      end else begin
        mon_e  = sb.pop_front();
        checks = checks + 2;
        if ((if_done && dm_done) || (dm_done !== mon_e.port)) begin
          failures = failures + 1;
          $display("FAIL sb_port if_done=%0b dm_done=%0b required_port=%0d", if_done, dm_done, mon_e.port);
        end
        if ((mon_e.port ? dm_rdata : if_rdata) !== mon_e.rdata) begin
          failures = failures + 1;
          $display("FAIL sb_rdata got=%h required=%h", mon_e.port ? dm_rdata : if_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic wait_done(input bit port, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (port ? dm_done : if_done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, if_done, dm_done, err_timeout} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b required=00000", {mem_req, mem_we, if_done, dm_done, err_timeout}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h required=0", {if_rdata, dm_rdata}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL reset_mem_regs got=%h required=0", {mem_addr, mem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch;
    int c;
    if_req = 1'b1; if_addr = 32'h40;
    mem_model[32'h40] = 32'h8C01_0004; mem_lat = 1;
    sb.push_back('{port: 1'b0, rdata: 32'h8C01_0004});
    #1;
    checks++; if ({if_stall, mem_req} !== 2'b10) begin failures++; $display("FAIL fetch_c0 stall,req got=%b required=10", {if_stall, mem_req}); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we, if_stall} !== 3'b101 || mem_addr !== 32'h40) begin failures++; $display("FAIL fetch_c1 req,we,stall=%b addr=%h required=101 40", {mem_req, mem_we, if_stall}, mem_addr); end
    wait_done(1'b0, 1, c);
    checks++; if (c != 1 || if_stall !== 1'b0 || if_rdata !== 32'h8C01_0004) begin failures++; $display("FAIL fetch_c2 cycles=%0d stall=%b rdata=%h required=1 0 8c010004", c, if_stall, if_rdata); end
    if_req = 1'b0; last_if = 32'h8C01_0004;
    @(negedge clk);
    checks++; if ({if_done, mem_req} !== 2'b00) begin failures++; $display("FAIL fetch_c3 done,req got=%b required=00", {if_done, mem_req}); end
  endtask

  task automatic test_priority;
    int c;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h80; mem_lat = 2;
    sb.push_back('{port: 1'b1, rdata: exp_dm_rdata});
    sb.push_back('{port: 1'b0, rdata: rd_model(32'h80)});
    last_if = rd_model(32'h80);
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL prio_dm_grant req,we=%b addr=%h wdata=%h required=11 10 deadbeef", {mem_req, mem_we}, mem_addr, mem_wdata); end
    wait_done(1'b1, 10, c);
    checks++; if (c != 2 || dm_rdata !== exp_dm_rdata) begin failures++; $display("FAIL prio_dm_done cycles=%0d rdata=%h required=2 %h", c, dm_rdata, exp_dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL prio_idle_gap req=%b required=0", mem_req); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h80) begin failures++; $display("FAIL prio_if_grant req,we=%b addr=%h required=10 80", {mem_req, mem_we}, mem_addr); end
    wait_done(1'b0, 10, c);
    checks++; if (c < 0) begin failures++; $display("FAIL prio_if_done timeout got=%0d required>=0", c); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    int n_done, n_if;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300; mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) sb.push_back('{port: 1'b0, rdata: rd_model(32'h300)});
      else            sb.push_back('{port: 1'b1, rdata: rd_model(32'h200)});
    end
    exp_dm_rdata = rd_model(32'h200); last_if = rd_model(32'h300);
    n_done = 0; n_if = 0;
    for (int i = 0; i < 100 && n_done < 10; i++) begin
      @(negedge clk);
      if (if_done || dm_done) n_done++;
      if (if_done) n_if++;
    end
    dm_req = 1'b0; if_req = 1'b0;
    checks++; if (n_done != 10 || n_if != 2) begin failures++; $display("FAIL starve_counts dones=%0d if_dones=%0d required=10 2", n_done, n_if); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int c;
    mem_dead = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    sb.push_back('{port: 1'b1, rdata: 32'h0});
    exp_dm_rdata = 32'h0;
    repeat (8) @(negedge clk);
    checks++; if ({err_timeout, mem_req} !== 2'b01) begin failures++; $display("FAIL timeout_pre err,req got=%b required=01", {err_timeout, mem_req}); end
    wait_done(1'b1, 10, c);
    checks++; if (c != 1 || err_timeout !== 1'b1 || dm_rdata !== 32'h0) begin failures++; $display("FAIL timeout_abort cycles=%0d err=%b rdata=%h required=1 1 0", c, err_timeout, dm_rdata); end
    dm_req = 1'b0; mem_dead = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h600;
    sb.push_back('{port: 1'b0, rdata: rd_model(32'h600)});
    last_if = rd_model(32'h600);
    wait_done(1'b0, 10, c);
    checks++; if (c != 2 || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky cycles=%0d err=%b required=2 1", c, err_timeout); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int c;
    mem_dead = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy req=%b required=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_async req=%b required=0", mem_req); end
    dm_req = 1'b0; mem_dead = 1'b0;
    exp_dm_rdata = 32'h0; last_if = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if ({dm_done, err_timeout, dm_rdata} !== 34'h0) begin failures++; $display("FAIL rstmid_clean done,err=%b rdata=%h required=00 0", {dm_done, err_timeout}, dm_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h740;
    sb.push_back('{port: 1'b0, rdata: rd_model(32'h740)});
    last_if = rd_model(32'h740);
    wait_done(1'b0, 10, c);
    checks++; if (c != 2 || if_rdata !== last_if) begin failures++; $display("FAIL rstmid_fetch cycles=%0d rdata=%h required=2 %h", c, if_rdata, last_if); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_ready_and_done_reqs;
    int c;
    force_ready = 1'b1;
    repeat (2) @(negedge clk);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_rdata !== last_if || dm_rdata !== exp_dm_rdata || mem_req !== 1'b0) begin failures++; $display("FAIL idle_ready if_rdata=%h dm_rdata=%h req=%b required=%h %h 0", if_rdata, dm_rdata, mem_req, last_if, exp_dm_rdata); end
    if_req = 1'b1; if_addr = 32'h800;
    sb.push_back('{port: 1'b0, rdata: rd_model(32'h800)});
    wait_done(1'b0, 10, c);
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h840;
    sb.push_back('{port: 1'b1, rdata: rd_model(32'h840)});
    exp_dm_rdata = rd_model(32'h840);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL done_ignores_req req=%b required=0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h840) begin failures++; $display("FAIL after_done_grant req=%b addr=%h required=1 840", mem_req, mem_addr); end
    wait_done(1'b1, 10, c);
    checks++; if (c != 1) begin failures++; $display("FAIL after_done_dm cycles=%0d required=1", c); end
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_idle_ready_and_done_reqs();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (read-only) and the data-memory stage port (read/write).
- Sits between the IF/MEM pipeline stages and the memory.
- Serialises accesses and drives per-port stall signals, so the pipeline registers hold while a port waits.
- Data port has priority, with a starvation limit that protects fetch; a watchdog flags and aborts hung transactions.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending (1..15)
TIMEOUT, 255, busy cycles without mem_ready before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address
if_stall  out  1  if_req && !if_done (combinational)
if_done  out  1  one-cycle completion pulse for fetch
if_rdata  out  DATA_W  fetched word, registered
dm_req  in  1  data request, level, held until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_stall  out  1  dm_req && !dm_done (combinational)
dm_done  out  1  one-cycle completion pulse for data
dm_rdata  out  DATA_W  load data, registered
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, only valid with mem_req
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_ready  in  1  memory completes the transaction in this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ready
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_req, mem_we, if_done, dm_done, err_timeout = 0.
  - if_rdata, dm_rdata, mem_addr, mem_wdata = 0; starve_cnt=0, wd_cnt=0.
  - Assertion mid-transaction drops mem_req immediately; no done pulse is produced.
- FSM states: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE transitions:
  - If dm_req && (!if_req || starve_cnt < STARVE_LIMIT), go to DM_BUSY.
  - Else if if_req, go to IF_BUSY.
  - Else stay in IDLE.
  - On a grant edge, latch addr, wdata and we (we=0 for fetch) into the mem_* registers and set mem_req=1.
- Starvation counter:
  - On a DM grant with if_req=1: starve_cnt++ (saturating).
  - On a DM grant with if_req=0, or on any IF grant: starve_cnt=0.
- BUSY states:
  - mem_req stays 1 and the mem_* registers are stable.
  - wd_cnt increments each cycle.
  - A cycle with mem_ready=1:
    - Reads capture mem_rdata into if_rdata or dm_rdata.
    - Writes leave dm_rdata unchanged.
    - Next state is DONE with mem_req=0 and wd_cnt=0.
  - If wd_cnt reaches TIMEOUT with no mem_ready:
    - err_timeout=1 (cleared only by reset).
    - The read destination is loaded with 0.
    - Next state is DONE with mem_req=0.
- DONE:
  - Registered if_done or dm_done=1 for exactly one cycle, for the owning port.
  - Requests are ignored in this cycle; always returns to IDLE.
  - The pipeline advances on the DONE edge, so the next request is evaluated in IDLE.
- Latency: a request seen in IDLE at cycle 0 gives mem_req at cycle 1. With mem_ready at cycle 1, done is at cycle 2 and IDLE at cycle 3. Minimum 3 cycles per access; one outstanding transaction at a time.
- Simultaneous first requests: data wins.
- A request dropped while busy is a protocol error. The transaction still completes and done still pulses.
- mem_ready outside BUSY is ignored.
- Outputs are never X after reset; if_stall and dm_stall are the only combinational outputs.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, IF_BUSY=1, DM_BUSY=2, DONE=3).
  - Default ADDR_W and DATA_W.
  - Port-ID constants (PORT_IF=0, PORT_DM=1) for the owner register.
- Sub-module arb_watchdog: 8-bit counter with enable, clear and terminal-count output; reused later for bus timeouts.
- Starvation counter and FSM stay inline.

Test Plan:
- Single fetch, if_addr=0x40, mem_ready at the first busy cycle, mem_rdata=0x8C010004:
  - mem_req at cycle 1 with mem_addr=0x40 and mem_we=0.
  - if_done at cycle 2 with if_rdata=0x8C010004.
  - if_stall high for cycles 0–1.
- Both ports request at cycle 0, dm write addr=0x10, wdata=0xDEADBEEF, memory latency 2:
  - DM served first, with mem_we=1 and mem_wdata=0xDEADBEEF.
  - dm_rdata unchanged.
  - IF is granted in the IDLE cycle after DONE.
- if_req and dm_req held continuously, STARVE_LIMIT=4:
  - Grant sequence is DM, DM, DM, DM, IF, DM…
  - starve_cnt returns to 0 after the IF grant.
- Memory never asserts mem_ready, TIMEOUT=8:
  - After 8 busy cycles, err_timeout=1 and dm_done pulses with dm_rdata=0.
  - err_timeout stays high through later transactions.
- rst_n pulled low in the middle of DM_BUSY:
  - mem_req falls asynchronously with no dm_done.
  - After release, state is IDLE and a new fetch completes normally.
- mem_ready pulsed while IDLE, and requests presented during DONE:
  - No capture occurs and no extra grant is made.
  - The state after DONE is always IDLE.
